// File: rtl/uart_tx64_sched_if.sv
// Bundle of scheduler-facing signals: two word requesters, the byte transmitter handshake, status.
// Pure wiring, no latency of its own.
// Backpressure is carried by req/ack on the requester side and tx_busy on the transmitter side.
interface uart_tx64_sched_if;
    logic        req_0;
    logic [63:0] data_0;
    logic        ack_0;
    logic        done_0;
    logic        req_1;
    logic [63:0] data_1;
    logic        ack_1;
    logic        done_1;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        owner;

    // Scheduler side.
    modport master (
        input  req_0, data_0, req_1, data_1, tx_busy,
        output ack_0, done_0, ack_1, done_1, tx_start, tx_data, busy, owner
    );

    // Requesters plus byte transmitter side.
    modport slave (
        output req_0, data_0, req_1, data_1, tx_busy,
        input  ack_0, done_0, ack_1, done_1, tx_start, tx_data, busy, owner
    );
endinterface

// File: rtl/uart_tx64_sched.sv
// Round-robin scheduler that serialises 64-bit words into eight UART byte transfers, MSB byte first.
// ack one cycle after req is sampled, first tx_start one cycle later; all outputs registered.
// Requests wait (req held) during a word; bytes wait while tx_busy is high; an idle gap follows each word.
module uart_tx64_sched #(
    parameter int CLK_F    = 50_000_000,
    parameter int UART_BPS = 115200,
    parameter int CLK_GOAL = CLK_F / UART_BPS,
    parameter int GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx64_sched_if.master bus
);
    localparam int GAP_CYC = GAP_BITS * CLK_GOAL;
    localparam int GAP_W   = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    // Last count value before leaving GAP; the gap lasts GAP_CYC cycles in total.
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        GAP
    } state_t;

    state_t           state, state_nxt;
    logic [63:0]      shift, shift_nxt;
    logic [2:0]       byte_cnt, byte_cnt_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
    logic             cur_owner, cur_owner_nxt;
    logic             last_owner, last_owner_nxt;
    logic             tx_start_r, tx_start_nxt;
    logic [7:0]       tx_data_r, tx_data_nxt;
    logic             ack0_r, ack0_nxt;
    logic             ack1_r, ack1_nxt;
    logic             done0_r, done0_nxt;
    logic             done1_r, done1_nxt;
    logic             busy_r, busy_nxt;
    logic             grant_vld;
    logic             grant_idx;

    // Round-robin pick: a lone request wins outright, contention goes to the requester not served last.
    always_comb begin
        grant_vld = bus.req_0 | bus.req_1;
        grant_idx = 1'b0;
        if (bus.req_0 && bus.req_1) begin
            grant_idx = ~last_owner;
        end else if (bus.req_1) begin
            grant_idx = 1'b1;
        end
    end

    // Next-state and next-output logic; every output is a one-cycle-late registered copy of *_nxt.
    always_comb begin
        state_nxt      = state;
        shift_nxt      = shift;
        byte_cnt_nxt   = byte_cnt;
        gap_cnt_nxt    = gap_cnt;
        cur_owner_nxt  = cur_owner;
        last_owner_nxt = last_owner;
        tx_start_nxt   = 1'b0;
        tx_data_nxt    = tx_data_r;
        ack0_nxt       = 1'b0;
        ack1_nxt       = 1'b0;
        done0_nxt      = 1'b0;
        done1_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (grant_vld) begin
                    shift_nxt      = grant_idx ? bus.data_1 : bus.data_0;
                    byte_cnt_nxt   = 3'd0;
                    cur_owner_nxt  = grant_idx;
                    last_owner_nxt = grant_idx;
                    ack0_nxt       = ~grant_idx;
                    ack1_nxt       = grant_idx;
                    state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                // Never start a byte on top of one still on the line.
                if (!bus.tx_busy) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = shift[63:56];
                    state_nxt    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (byte_cnt != 3'd7) begin
                        shift_nxt    = {shift[55:0], 8'h00};
                        byte_cnt_nxt = byte_cnt + 3'd1;
                        state_nxt    = ISSUE;
                    end else begin
                        done0_nxt   = ~cur_owner;
                        done1_nxt   = cur_owner;
                        gap_cnt_nxt = '0;
                        state_nxt   = (GAP_CYC > 0) ? GAP : IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs; reset abandons any word in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift      <= '0;
            byte_cnt   <= 3'd0;
            gap_cnt    <= '0;
            cur_owner  <= 1'b0;
            last_owner <= 1'b1;
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'h00;
            ack0_r     <= 1'b0;
            ack1_r     <= 1'b0;
            done0_r    <= 1'b0;
            done1_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift      <= shift_nxt;
            byte_cnt   <= byte_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            cur_owner  <= cur_owner_nxt;
            last_owner <= last_owner_nxt;
            tx_start_r <= tx_start_nxt;
            tx_data_r  <= tx_data_nxt;
            ack0_r     <= ack0_nxt;
            ack1_r     <= ack1_nxt;
            done0_r    <= done0_nxt;
            done1_r    <= done1_nxt;
            busy_r     <= busy_nxt;
        end
    end

    assign bus.ack_0    = ack0_r;
    assign bus.ack_1    = ack1_r;
    assign bus.done_0   = done0_r;
    assign bus.done_1   = done1_r;
    assign bus.tx_start = tx_start_r;
    assign bus.tx_data  = tx_data_r;
    assign bus.busy     = busy_r;
    assign bus.owner    = cur_owner;

endmodule

// File: tb/tb_uart_tx64_sched.sv
// Directed bench for uart_tx64_sched with a behavioural byte transmitter model.
// Small clock/baud ratio keeps words short: CLK_GOAL = 8, gap = 16 cycles.
// Inputs and the transmitter model are driven on the falling edge.
module tb_uart_tx64_sched;
    localparam int CLK_F    = 1000;
    localparam int UART_BPS = 125;
    localparam int CG       = CLK_F / UART_BPS;
    localparam int GAP_BITS = 2;
    localparam int GAP_CYC  = GAP_BITS * CG;
    localparam int BYTE_CYC = 10 * CG;
    localparam int TMO      = 5000;
    localparam logic [63:0] W0 = 64'h2d7e66091ed0a403;
    localparam logic [63:0] W1 = 64'hd253328dd2c0fc3c;
    localparam logic [63:0] W2 = 64'h8162476652bdd1d0;

    logic clk        = 1'b0;
    logic rst        = 1'b1;
    logic hold_busy  = 1'b0;
    logic model_busy = 1'b0;
    int   model_cnt  = 0;
    int   cyc        = 0;
    int   total      = 0;
    int   bad        = 0;

    logic [7:0] txq[$];
    logic       ownq[$];
    int n_ack0 = 0, n_ack1 = 0, n_done0 = 0, n_done1 = 0;
    int ack_cyc = 0, fall_cyc = 0, ack_to_start = 0, done_lat = 0;
    int ibg_bad = 0, start_in_busy = 0;
    bit pend = 1'b0;

    bit ok;
    int at_ack, at_done, nd, sb;

    uart_tx64_sched_if bus();
    assign bus.tx_busy = model_busy | hold_busy;

    uart_tx64_sched #(
        .CLK_F   (CLK_F),
        .UART_BPS(UART_BPS),
        .GAP_BITS(GAP_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte transmitter model and event recorder.
    always @(negedge clk) begin
        if (bus.tx_start) begin
            if (bus.tx_busy) start_in_busy++;
            if (pend) begin
                ack_to_start = cyc - ack_cyc;
                pend = 1'b0;
            end else if (cyc - fall_cyc != 2) begin
                ibg_bad++;
            end
            txq.push_back(bus.tx_data);
            model_busy = 1'b1;
            model_cnt  = BYTE_CYC;
        end else if (model_busy) begin
            model_cnt--;
            if (model_cnt == 0) begin
                model_busy = 1'b0;
                fall_cyc   = cyc;
            end
        end
        if (bus.ack_0 || bus.ack_1) begin
            ack_cyc = cyc;
            pend    = 1'b1;
            ownq.push_back(bus.owner);
        end
        if (bus.ack_0)  n_ack0++;
        if (bus.ack_1)  n_ack1++;
        if (bus.done_0) n_done0++;
        if (bus.done_1) n_done1++;
        if (bus.done_0 || bus.done_1) done_lat = cyc - fall_cyc;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // which: 0 ack_0, 1 ack_1, 2 done_0, 3 done_1
    task automatic wait_flag(input int which, output bit seen, output int at);
        seen = 1'b0;
        at   = 0;
        for (int i = 0; i < TMO && !seen; i++) begin
            @(negedge clk);
            case (which)
                0:       seen = bus.ack_0;
                1:       seen = bus.ack_1;
                2:       seen = bus.done_0;
                default: seen = bus.done_1;
            endcase
            at = cyc;
        end
    endtask

    task automatic check_word(input string tag, input logic [63:0] w);
        logic [63:0] got;
        @(negedge clk);
        chk({tag, "_nbytes"}, txq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            got = (i < txq.size()) ? {56'h0, txq[i]} : 64'hdead;
            chk($sformatf("%s_b%0d", tag, i), got, {56'h0, w[63-8*i -: 8]});
        end
        txq.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_ack0 = 0; n_ack1 = 0; n_done0 = 0; n_done1 = 0;
        txq.delete();
        ownq.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t reached, limit 1000000", $time);
        $fatal(1);
    end

    initial begin
        bus.req_0  = 1'b0;
        bus.req_1  = 1'b0;
        bus.data_0 = '0;
        bus.data_1 = '0;
        repeat (3) @(negedge clk);

        // Reset state while rst is held
        chk("rst_busy",     bus.busy,     0);
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_tx_data",  bus.tx_data,  0);
        chk("rst_ack0",     bus.ack_0,    0);
        chk("rst_ack1",     bus.ack_1,    0);
        chk("rst_done0",    bus.done_0,   0);
        chk("rst_done1",    bus.done_1,   0);
        chk("rst_owner",    bus.owner,    0);
        rst = 1'b0;
        @(negedge clk);

        // Single word from requester 0
        bus.data_0 = W0;
        bus.req_0  = 1'b1;
        wait_flag(0, ok, at_ack);
        chk("s1_ack0", ok, 1);
        bus.req_0 = 1'b0;
        chk("s1_owner", bus.owner, 0);
        wait_flag(2, ok, at_done);
        chk("s1_done0", ok, 1);
        check_word("s1", W0);
        chk("s1_ack_to_start", ack_to_start, 1);
        chk("s1_done_lat", done_lat, 1);
        repeat (GAP_CYC + 4) @(negedge clk);
        chk("s1_idle", bus.busy, 0);
        chk("s1_n_ack0", n_ack0, 1);
        chk("s1_n_done0", n_done0, 1);
        chk("s1_n_ack1", n_ack1, 0);
        chk("s1_n_done1", n_done1, 0);

        // Contention right after reset: 0 first, then 1, twice
        do_reset();
        bus.data_0 = W0;
        bus.data_1 = W1;
        for (int r = 0; r < 2; r++) begin
            bus.req_0 = 1'b1;
            bus.req_1 = 1'b1;
            wait_flag(0, ok, at_ack);
            chk($sformatf("s2r%0d_ack0", r), ok, 1);
            bus.req_0 = 1'b0;
            wait_flag(2, ok, at_done);
            check_word($sformatf("s2r%0d_w0", r), W0);
            wait_flag(1, ok, at_ack);
            chk($sformatf("s2r%0d_ack1", r), ok, 1);
            bus.req_1 = 1'b0;
            chk($sformatf("s2r%0d_owner1", r), bus.owner, 1);
            wait_flag(3, ok, at_done);
            chk($sformatf("s2r%0d_done1", r), ok, 1);
            check_word($sformatf("s2r%0d_w1", r), W1);
            repeat (GAP_CYC + 4) @(negedge clk);
        end
        chk("s2_nown", ownq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s2_own%0d", i), (i < ownq.size()) ? ownq[i] : 1'bx, i % 2);
        end

        // Starvation: req_0 held, then req_1 takes the very next grant; gap timing
        ownq.delete();
        n_ack0 = 0;
        bus.data_0 = W0;
        bus.req_0  = 1'b1;
        wait_flag(0, ok, at_ack);
        bus.data_0 = W2;
        wait_flag(2, ok, at_done);
        check_word("s3_w0", W0);
        wait_flag(0, ok, at_ack);
        chk("s3_regrant0", ok, 1);
        chk("s3_gap0", at_ack - at_done, GAP_CYC + 1);
        bus.data_1 = W1;
        bus.req_1  = 1'b1;
        wait_flag(2, ok, at_done);
        check_word("s3_w2", W2);
        wait_flag(1, ok, at_ack);
        chk("s3_ack1_next", ok, 1);
        bus.req_0 = 1'b0;
        bus.req_1 = 1'b0;
        chk("s3_gap1", at_ack - at_done, GAP_CYC + 1);
        chk("s3_n_ack0", n_ack0, 2);
        wait_flag(3, ok, at_done);
        check_word("s3_w1", W1);
        repeat (GAP_CYC + 4) @(negedge clk);

        // Busy hold-off after ack
        bus.data_0 = W0;
        bus.req_0  = 1'b1;
        wait_flag(0, ok, at_ack);
        bus.req_0 = 1'b0;
        hold_busy = 1'b1;
        sb = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.tx_start) sb++;
        end
        chk("s4_no_start_hold", sb, 0);
        hold_busy = 1'b0;
        @(negedge clk);
        chk("s4_start_release", bus.tx_start, 1);
        chk("s4_first_byte", bus.tx_data, 8'h2d);
        wait_flag(2, ok, at_done);
        chk("s4_done0", ok, 1);
        check_word("s4", W0);
        repeat (GAP_CYC + 4) @(negedge clk);

        // Reset in the middle of byte 3
        bus.data_0 = W0;
        bus.req_0  = 1'b1;
        wait_flag(0, ok, at_ack);
        bus.req_0 = 1'b0;
        for (int i = 0; i < TMO && txq.size() < 4; i++) @(negedge clk);
        chk("s5_at_byte3", txq.size(), 4);
        repeat (CG) @(negedge clk);
        nd  = n_done0;
        rst = 1'b1;
        @(negedge clk);
        chk("s5_rst_busy", bus.busy, 0);
        chk("s5_rst_tx_start", bus.tx_start, 0);
        chk("s5_rst_tx_data", bus.tx_data, 0);
        rst = 1'b0;
        repeat (2 * BYTE_CYC) @(negedge clk);
        chk("s5_no_done0", n_done0, nd);
        chk("s5_idle", bus.busy, 0);
        txq.delete();
        bus.data_1 = W1;
        bus.req_1  = 1'b1;
        wait_flag(1, ok, at_ack);
        chk("s5_ack1", ok, 1);
        bus.req_1 = 1'b0;
        chk("s5_owner1", bus.owner, 1);
        wait_flag(3, ok, at_done);
        chk("s5_done1", ok, 1);
        check_word("s5", W1);

        chk("start_in_busy", start_in_busy, 0);
        chk("interbyte_bad", ibg_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
